fixed_fma_pipe: RTL and testbench

- Parametrised, pipelined fixed-point fused multiply-add for the shader ALU datapath.
- Computes a*b±c or a*b+acc at full internal precision with a single final rounding. Rounds per operation (truncate or round-half-even) and saturates to the input Q format.
- Full valid/ready backpressure; one operation per cycle when not stalled.
- Internal accumulator supports dot-product and MAC sequences.

---
 rtl/fixed_fma_pipe_pkg.sv | 29 ++
 rtl/fixed_fma_pipe_round_sat.sv | 42 ++++
 rtl/fixed_fma_pipe.sv | 138 +++++++++++++
 tb/tb_fixed_fma_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_fma_pipe_pkg.sv
// Shared encodings and width helpers for the fixed-point FMA datapath.
package fma_pkg;

  typedef enum logic [1:0] {
    OP_FMA  = 2'd0,
    OP_FMS  = 2'd1,
    OP_LOAD = 2'd2,
    OP_ACC  = 2'd3
  } op_e;

  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_RHE   = 1'b1
  } rnd_e;

  function automatic int unsigned dw_f(input int unsigned intw, input int unsigned fracw);
    return intw + fracw;
  endfunction

  function automatic int unsigned cw_f(input int unsigned intw, input int unsigned fracw);
    return intw + 2 * fracw;
  endfunction

  // One carry bit above the full product keeps product +/- addend exact.
  function automatic int unsigned sw_f(input int unsigned intw, input int unsigned fracw);
    return 2 * (intw + fracw) + 1;
  endfunction

endpackage

// File: rtl/fixed_fma_pipe_round_sat.sv
// Combinational round (truncate / round-half-even), saturate and clamp flag.
module fma_round_sat
  import fma_pkg::*;
#(
  parameter int unsigned FRACW = 16,
  parameter int unsigned DW    = 32,
  parameter int unsigned SW    = 65
) (
  input  logic [SW-1:0] s_i,
  input  logic          rnd_i,
  output logic [DW-1:0] y_o,
  output logic          sat_o
);

  localparam int unsigned RW = SW + 1;
  localparam logic signed [RW-1:0] MAXV = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [FRACW-1:0]     HALF = {1'b1, {(FRACW-1){1'b0}}};

  logic signed [RW-1:0] kept;
  logic signed [RW-1:0] rounded;
  logic [FRACW-1:0]     drop;
  logic                 inc;

  always_comb begin
    kept    = $signed({s_i[SW-1], s_i}) >>> FRACW;
    drop    = s_i[FRACW-1:0];
    inc     = (rnd_i == RND_RHE) && ((drop > HALF) || ((drop == HALF) && kept[0]));
    // Increment at SW+1 bits so a rounding carry is seen by the clamp.
    rounded = kept + {{(RW-1){1'b0}}, inc};
    sat_o   = 1'b0;
    y_o     = rounded[DW-1:0];
    if (rounded > MAXV) begin
      sat_o = 1'b1;
      y_o   = MAXV[DW-1:0];
    end else if (rounded < MINV) begin
      sat_o = 1'b1;
      y_o   = MINV[DW-1:0];
    end
  end

endmodule

// File: rtl/fixed_fma_pipe.sv
// Pipelined fixed-point fused multiply-add with internal accumulator and
// single-point rounding/saturation; whole pipe stalls on output backpressure.
module fixed_fma_pipe
  import fma_pkg::*;
#(
  parameter int unsigned INTW       = 16,
  parameter int unsigned FRACW      = 16,
  parameter int unsigned MUL_STAGES = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     op,
  input  logic                           rnd,
  input  logic [dw_f(INTW, FRACW)-1:0]   a,
  input  logic [dw_f(INTW, FRACW)-1:0]   b,
  input  logic [cw_f(INTW, FRACW)-1:0]   c,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [dw_f(INTW, FRACW)-1:0]   out,
  output logic [sw_f(INTW, FRACW)-1:0]   out_wide,
  output logic                           sat
);

  localparam int unsigned DW = dw_f(INTW, FRACW);
  localparam int unsigned CW = cw_f(INTW, FRACW);
  localparam int unsigned SW = sw_f(INTW, FRACW);
  localparam int unsigned PW = 2 * DW;

  typedef struct packed {
    logic          v;
    op_e           op;
    logic          rnd;
    logic [CW-1:0] c;
    logic [PW-1:0] p;
  } mstage_t;

  logic          adv;
  logic [PW-1:0] prod_d;
  mstage_t       m_d [MUL_STAGES];
  mstage_t       m_q [MUL_STAGES];
  mstage_t       m_last;

  logic [SW-1:0] p_ext, c_ext, s_d;
  logic [SW-1:0] acc_q, a_s_q;
  logic          a_v_q, a_rnd_q;

  logic [DW-1:0] rs_y;
  logic          rs_sat;
  logic          out_valid_q, sat_q;
  logic [DW-1:0] out_q;
  logic [SW-1:0] out_wide_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign prod_d   = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});

  always_comb begin
    m_d[0] = '{v: in_valid, op: op_e'(op), rnd: rnd, c: c, p: prod_d};
    for (int unsigned i = 1; i < MUL_STAGES; i++) begin
      m_d[i] = m_q[i-1];
    end
  end

  for (genvar i = 0; i < MUL_STAGES; i++) begin : g_mul
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        m_q[i] <= '0;
      end else if (adv) begin
        m_q[i] <= m_d[i];
      end
    end
  end

  assign m_last = m_q[MUL_STAGES-1];

  always_comb begin
    p_ext = {{(SW-PW){m_last.p[PW-1]}}, m_last.p};
    c_ext = {{(SW-CW){m_last.c[CW-1]}}, m_last.c};
    case (m_last.op)
      OP_FMS:  s_d = p_ext - c_ext;
      OP_ACC:  s_d = p_ext + acc_q;
      default: s_d = p_ext + c_ext;
    endcase
  end

  // acc is written in the same cycle stage A advances, so a following ACC
  // one cycle behind already sees the updated value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_v_q   <= 1'b0;
      a_rnd_q <= 1'b0;
      a_s_q   <= '0;
      acc_q   <= '0;
    end else if (adv) begin
      a_v_q   <= m_last.v;
      a_rnd_q <= m_last.rnd;
      a_s_q   <= s_d;
      if (m_last.v && (m_last.op == OP_LOAD || m_last.op == OP_ACC)) begin
        acc_q <= s_d;
      end
    end
  end

  fma_round_sat #(
    .FRACW(FRACW),
    .DW   (DW),
    .SW   (SW)
  ) u_round_sat (
    .s_i  (a_s_q),
    .rnd_i(a_rnd_q),
    .y_o  (rs_y),
    .sat_o(rs_sat)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_wide_q  <= '0;
      sat_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= a_v_q;
      if (a_v_q) begin
        out_q      <= rs_y;
        out_wide_q <= a_s_q;
        sat_q      <= rs_sat;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_wide  = out_wide_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fixed_fma_pipe.sv
// Scoreboard bench for fixed_fma_pipe: arithmetic reference model, random ops
// with random backpressure, plus directed rounding/saturation/accumulate cases.
module tb_fixed_fma_pipe;

  localparam int unsigned INTW       = 16;
  localparam int unsigned FRACW      = 16;
  localparam int unsigned MUL_STAGES = 1;
  localparam int          L          = MUL_STAGES + 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'd0;
  logic        rnd = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [47:0] c = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic [64:0] out_wide;
  logic        sat;

  fixed_fma_pipe #(
    .INTW      (INTW),
    .FRACW     (FRACW),
    .MUL_STAGES(MUL_STAGES)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rnd      (rnd),
    .a        (a),
    .b        (b),
    .c        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_wide (out_wide),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o;
    logic [64:0] w;
    logic        s;
  } exp_t;

  exp_t               sb[$];
  int                 n_checks = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  int                 acc_edge = 0;
  int                 rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  logic signed [64:0] macc = '0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Exact arithmetic on 128 bits, wrapped to the 65-bit sum, then rounded
  // from floor/remainder and clamped to the Q16.16 range.
  function automatic exp_t model(input logic [1:0] o, input logic r, input logic [31:0] x,
                                 input logic [31:0] y, input logic [47:0] z);
    logic signed [127:0] p, add, s, q, rem;
    exp_t e;
    p   = $signed({{96{x[31]}}, x}) * $signed({{96{y[31]}}, y});
    add = (o == 2'd3) ? {{63{macc[64]}}, macc} : {{80{z[47]}}, z};
    s   = (o == 2'd1) ? p - add : p + add;
    s   = {{63{s[64]}}, s[64:0]};
    if (o[1]) macc = s[64:0];
    q   = s >>> 16;
    rem = s - (q <<< 16);
    if (r && (rem > 32768 || (rem == 32768 && q[0]))) q = q + 1;
    e.w = s[64:0];
    e.s = 1'b1;
    if (q > 128'sh7FFFFFFF) e.o = 32'h7FFFFFFF;
    else if (q < -128'sh80000000) e.o = 32'h80000000;
    else begin
      e.o = q[31:0];
      e.s = 1'b0;
    end
    return e;
  endfunction

  // Called right after a rising edge; returns right after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic r, input logic [31:0] x,
                       input logic [31:0] y, input logic [47:0] z,
                       input bit use_k, input logic [31:0] k_out, input logic k_sat);
    exp_t e;
    int   waited;
    bit   done;
    waited = 0;
    done = 0;
    op = o; rnd = r; a = x; b = y; c = z; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(o, r, x, y, z);
        if (use_k) begin
          e.o = k_out;
          e.s = k_sat;
        end
        sb.push_back(e);
        acc_edge = cyc + 1;
        done = 1;
      end else begin
        waited++;
        if (waited > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL issue_timeout: actual in_ready=0 for %0d cycles required 1", waited);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: actual out=%0h required no output", out);
      end else begin
        e = sb.pop_front();
        check("out", out, e.o);
        check("out_wide", out_wide, e.w);
        check("sat", sat, e.s);
      end
    end
  end

  function automatic logic [31:0] rand_operand();
    int unsigned sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return $urandom;
      1:       return 32'($signed($urandom_range(0, 32'h7FFFF)) - 32'sh40000);
      2:       return 32'($signed($urandom_range(0, 255)) - 32'sd128);
      default: return 32'($signed($urandom_range(0, 32'h3FFFFF)) - 32'sh200000);
    endcase
  endfunction

  function automatic logic [47:0] rand_addend();
    logic [63:0] t;
    t = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 0) return t[47:0];
    return {{24{t[23]}}, t[23:0]};
  endfunction

  initial begin
    bit seen;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_out_wide", out_wide, 0);
    check("rst_sat", sat, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Basic FMA and accept-to-output latency.
    issue(2'd0, 1'b0, 32'h00018000, 32'h00020000, 48'h0_4000_0000, 1, 32'h00034000, 1'b0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("latency", 128'(cyc - acc_edge + 1), 128'(L));
    @(posedge clk); #1;
    drain();

    issue(2'd1, 1'b0, 32'h00018000, 32'h00020000, 48'h0_4000_0000, 1, 32'h0002C000, 1'b0);
    issue(2'd0, 1'b1, 32'h00000001, 32'h00008000, 48'h0, 1, 32'h00000000, 1'b0);
    issue(2'd0, 1'b1, 32'h00000003, 32'h00008000, 48'h0, 1, 32'h00000002, 1'b0);
    issue(2'd0, 1'b0, 32'h00000003, 32'h00008000, 48'h0, 1, 32'h00000001, 1'b0);
    issue(2'd0, 1'b0, 32'hFFFFFFFD, 32'h00008000, 48'h0, 1, 32'hFFFFFFFE, 1'b0);
    issue(2'd0, 1'b0, 32'h7FFF0000, 32'h00020000, 48'h0, 1, 32'h7FFFFFFF, 1'b1);
    issue(2'd0, 1'b0, 32'h80000000, 32'h00020000, 48'h0, 1, 32'h80000000, 1'b1);
    drain();

    // Accumulator chain, an FMA in between must not disturb acc.
    issue(2'd2, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00010000, 1'b0);
    issue(2'd3, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00020000, 1'b0);
    issue(2'd3, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00030000, 1'b0);
    issue(2'd3, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00040000, 1'b0);
    issue(2'd0, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00010000, 1'b0);
    issue(2'd3, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00050000, 1'b0);
    drain();

    // Six ops against a stalled output for 8 cycles.
    rdy_mode = 2;
    fork
      begin
        issue(2'd2, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00010000, 1'b0);
        issue(2'd3, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00020000, 1'b0);
        issue(2'd0, 1'b0, 32'h00020000, 32'h00010000, 48'h0, 1, 32'h00020000, 1'b0);
        issue(2'd3, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00030000, 1'b0);
        issue(2'd1, 1'b0, 32'h00010000, 32'h00010000, 48'h0_8000_0000, 1, 32'h00008000, 1'b0);
        issue(2'd3, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00040000, 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        rdy_mode = 0;
      end
    join
    drain();

    // Random ops with random backpressure and idle gaps.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_operand(), rand_operand(),
            rand_addend(), 0, 32'h0, 1'b0);
    end
    rdy_mode = 0;
    drain();

    // Reset with three operations in flight.
    rdy_mode = 2;
    @(posedge clk); #1;
    issue(2'd2, 1'b0, 32'h00030000, 32'h00010000, 48'h0, 0, 32'h0, 1'b0);
    issue(2'd3, 1'b0, 32'h00030000, 32'h00010000, 48'h0, 0, 32'h0, 1'b0);
    issue(2'd0, 1'b1, 32'h00050000, 32'h00010000, 48'h0, 0, 32'h0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_wide", out_wide, 0);
    check("flush_in_ready", in_ready, 1);
    sb.delete();
    macc = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    issue(2'd3, 1'b0, 32'h00010000, 32'h00010000, 48'h0, 1, 32'h00010000, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
